instruction_fetch_unit: RTL and testbench

//   Fetch stage feeding instructiondecoder: holds PC, reads the 49-bit instruction ROM, latches it into the

---
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: ROM port, branch inputs and the IR/valid outputs to the instruction decoder.
// The fetch unit takes the master modport; the ROM/decoder side (or a bench) takes the slave.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 49
);
   logic               stall;
   logic               zero_flag;
   logic [INSTR_W-1:0] rom_data;
   logic               rom_en;
   logic [ADDR_W-1:0]  rom_addr;
   logic [ADDR_W-1:0]  pc;
   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic               halted;

   modport master (
      input  stall, zero_flag, rom_data,
      output rom_en, rom_addr, pc, instruction, instr_valid, halted
   );

   modport slave (
      output stall, zero_flag, rom_data,
      input  rom_en, rom_addr, pc, instruction, instr_valid, halted
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: REQ/WAIT/ISSUE cadence, instruction register, BZ/BNZ/BRA resolved locally.
// Define IFU_HALT_EN to make opcode 5'h1F park the unit in a HALT state until reset.
module instruction_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 49,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   instruction_fetch_unit_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
`ifdef IFU_HALT_EN
   localparam logic [2:0] S_HALT  = 3'd4;
   localparam logic [4:0] OP_HALT = 5'h1F;
`endif
   localparam logic [4:0] OP_BZ   = 5'h10;
   localparam logic [4:0] OP_BNZ  = 5'h11;
   localparam logic [4:0] OP_BRA  = 5'h12;

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               valid_q, valid_d;
   logic [4:0]         ir_op;
   logic [ADDR_W-1:0]  target;
`ifdef IFU_HALT_EN
   logic               halted_q, halted_d;
`endif

   // Branches (and HALT when enabled) never reach the decoder.
   function automatic logic executable(input logic [4:0] op);
      logic ok;
      ok = !(op inside {OP_BZ, OP_BNZ, OP_BRA});
`ifdef IFU_HALT_EN
      if (op == OP_HALT) ok = 1'b0;
`endif
      return ok;
   endfunction

   assign ir_op  = ir_q[INSTR_W-1 -: 5];
   assign target = ir_q[ADDR_W-1:0];

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      valid_d = 1'b0;
`ifdef IFU_HALT_EN
      halted_d = halted_q;
`endif
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ:  if (!bus.stall) state_d = S_WAIT;
         S_WAIT: begin
            ir_d    = bus.rom_data;
            valid_d = executable(bus.rom_data[INSTR_W-1 -: 5]);
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            ir_d    = '0;
            state_d = S_REQ;
            pc_d    = pc_q + ADDR_W'(1);
            if ((ir_op == OP_BRA) ||
                (ir_op == OP_BZ  &&  bus.zero_flag) ||
                (ir_op == OP_BNZ && !bus.zero_flag))
               pc_d = target;
`ifdef IFU_HALT_EN
            if (ir_op == OP_HALT) begin
               pc_d     = pc_q;
               halted_d = 1'b1;
               state_d  = S_HALT;
            end
`endif
         end
`ifdef IFU_HALT_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         valid_q <= 1'b0;
`ifdef IFU_HALT_EN
         halted_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         valid_q <= valid_d;
`ifdef IFU_HALT_EN
         halted_q <= halted_d;
`endif
      end
   end

   assign bus.rom_en      = (state_q == S_REQ) && !bus.stall;
   assign bus.rom_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.instruction = ir_q;
   assign bus.instr_valid = valid_q;
`ifdef IFU_HALT_EN
   assign bus.halted      = halted_q;
`else
   assign bus.halted      = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: per-cycle behavioural model plus directed
// pins (branch paths, wrap, stall, reset mid-fetch, halt) and a randomized ROM/stall/zero_flag run.
module tb_instruction_fetch_unit;
   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 49;
   localparam logic [4:0] ADD = 5'h01, SUB = 5'h02, BZ = 5'h10, BNZ = 5'h11, BRA = 5'h12, HLT = 5'h1F;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   instruction_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous ROM: data appears one edge after rom_en.
   logic [INSTR_W-1:0] rom [256];
   always @(posedge clk) if (bus.rom_en === 1'b1) bus.rom_data <= rom[bus.rom_addr];

   function automatic logic [INSTR_W-1:0] mk(input logic [4:0] op, input logic [31:0] lit);
      return {op, 2'b01, 5'd2, 5'd1, lit};
   endfunction

   // ---------------- behavioural model ----------------
   typedef enum int {PH_IDLE, PH_FETCH, PH_LATCH, PH_EXEC, PH_HALT} phase_t;
   phase_t             m_ph   = PH_IDLE;
   logic [ADDR_W-1:0]  m_pc   = '0;
   logic [INSTR_W-1:0] m_ir   = '0;
   logic               m_halt = 1'b0;
   logic [ADDR_W-1:0]  fetch_log[$];

   function automatic logic is_halt(input logic [4:0] op);
`ifdef IFU_HALT_EN
      return op == HLT;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic issues(input logic [4:0] op);
      return !(op == BZ || op == BNZ || op == BRA || is_halt(op));
   endfunction

   function automatic logic [ADDR_W-1:0] next_pc(input logic [INSTR_W-1:0] w,
                                                  input logic [ADDR_W-1:0] pc, input logic z);
      int unsigned t;
      logic [4:0] op;
      op = w[48:44];
      t  = w[31:0] % 256;
      if (is_halt(op)) return pc;
      if (op == BRA || (op == BZ && z) || (op == BNZ && !z)) return ADDR_W'(t);
      return ADDR_W'((int'(pc) + 1) % 256);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         m_ph = PH_IDLE; m_pc = '0; m_ir = '0; m_halt = 1'b0;
      end
      check("rom_en",      bus.rom_en,      (m_ph == PH_FETCH) && !bus.stall);
      check("rom_addr",    bus.rom_addr,    m_pc);
      check("pc",          bus.pc,          m_pc);
      check("instruction", bus.instruction, (m_ph == PH_EXEC) ? m_ir : '0);
      check("instr_valid", bus.instr_valid, (m_ph == PH_EXEC) && issues(m_ir[48:44]));
      check("halted",      bus.halted,      m_halt);
      if (bus.rom_en === 1'b1) fetch_log.push_back(bus.rom_addr);
      if (!rst) begin
         case (m_ph)
            PH_IDLE:  m_ph = PH_FETCH;
            PH_FETCH: if (!bus.stall) begin m_ir = rom[m_pc]; m_ph = PH_LATCH; end
            PH_LATCH: m_ph = PH_EXEC;
            PH_EXEC: begin
               if (is_halt(m_ir[48:44])) begin m_halt = 1'b1; m_ph = PH_HALT; end
               else m_ph = PH_FETCH;
               m_pc = next_pc(m_ir, m_pc, bus.zero_flag);
            end
            default: m_ph = PH_HALT;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_directed();
      for (int i = 0; i < 256; i++) rom[i] = mk(ADD, 32'(i));
      rom[8'h00] = mk(ADD, 32'd5);
      rom[8'h01] = mk(SUB, 32'd7);
      rom[8'h02] = mk(BRA, 32'h0000_0040);
      rom[8'h40] = mk(BZ,  32'h0000_0010);
      rom[8'h41] = mk(BNZ, 32'h0000_0010);
      rom[8'h10] = mk(BRA, 32'hFFFF_FF23);
      rom[8'h23] = mk(BRA, 32'h0000_00FF);
      rom[8'hFF] = mk(ADD, 32'd9);
   endtask

   task automatic pin_fetches(input string tag, input logic [ADDR_W-1:0] exp [9]);
      check({tag, "_fetch_count_ok"}, 64'(fetch_log.size() >= 9), 64'd1);
      for (int i = 0; i < 9; i++)
         check({tag, "_fetch_addr"}, (i < fetch_log.size()) ? 64'(fetch_log[i]) : 64'hX, 64'(exp[i]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] exp_z1 [9];
      logic [ADDR_W-1:0] exp_z0 [9];
      logic [ADDR_W-1:0] pc_ref;
      bit ok;
      int vcount;
      exp_z1 = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h10, 8'h23, 8'hFF, 8'h00, 8'h01};
      exp_z0 = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h10, 8'h23, 8'hFF, 8'h00};

      rst = 1'b1; bus.stall = 1'b0; bus.zero_flag = 1'b1;
      load_directed();
      cycles(2);
      check("reset_pc", bus.pc, 0);
      check("reset_ir", bus.instruction, 0);
      rst = 1'b0; fetch_log.delete();
      cycles(1);
      check("first_rom_en", bus.rom_en, 1);
      cycles(40);
      pin_fetches("zf1", exp_z1);

      // BZ not taken / BNZ taken path
      rst = 1'b1; cycles(2);
      rst = 1'b0; bus.zero_flag = 1'b0; fetch_log.delete();
      cycles(40);
      pin_fetches("zf0", exp_z0);

      // stall held in REQ
      bus.stall = 1'b1;
      cycles(3);
      pc_ref = m_pc;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_rom_en", bus.rom_en, 0);
         check("stall_valid",  bus.instr_valid, 0);
         check("stall_pc",     bus.pc, pc_ref);
      end
      @(posedge clk); #1 bus.stall = 1'b0;
      @(negedge clk);
      check("unstall_rom_en",   bus.rom_en, 1);
      check("unstall_rom_addr", bus.rom_addr, pc_ref);

      // reset asserted in the middle of WAIT
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.rom_en === 1'b1 && bus.pc != 0) ok = 1'b1;
      end
      check("reach_req_nonzero_pc", ok, 1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("midwait_rst_pc",    bus.pc, 0);
      check("midwait_rst_ir",    bus.instruction, 0);
      check("midwait_rst_valid", bus.instr_valid, 0);
      check("midwait_rst_rom_en", bus.rom_en, 0);
      for (int i = 0; i < 256; i++) begin
         logic [4:0] op;
         case ($urandom_range(0, 7))
            0:       op = BRA;
            1:       op = BZ;
            2:       op = BNZ;
            default: op = $urandom_range(0, 1) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(19, 30));
         endcase
         rom[i] = {op, 2'($urandom), 5'($urandom), 5'($urandom), 32'($urandom)};
      end
      cycles(1);
      rst = 1'b0;
      cycles(1);
      check("release_rom_en",   bus.rom_en, 1);
      check("release_rom_addr", bus.rom_addr, 0);

      // randomized run
      for (int i = 0; i < 1500; i++) begin
         bus.stall     = ($urandom_range(0, 3) == 0);
         bus.zero_flag = $urandom_range(0, 1);
         cycles(1);
      end

      // halt opcode at address 3
      rst = 1'b1; bus.stall = 1'b0;
      rom[0] = mk(ADD, 32'd1); rom[1] = mk(SUB, 32'd2); rom[2] = mk(ADD, 32'd3);
      rom[3] = mk(HLT, 32'd0); rom[4] = mk(ADD, 32'd4); rom[5] = mk(ADD, 32'd5);
      cycles(2);
      rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         @(negedge clk);
         vcount += int'(bus.instr_valid);
      end
`ifdef IFU_HALT_EN
      check("halt_valid_pulses", vcount, 3);
      check("halt_pc",     bus.pc, 3);
      check("halt_flag",   bus.halted, 1);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rom_en !== 1'b0 || bus.halted !== 1'b1) ok = 1'b0;
      end
      check("halt_parked_20", ok, 1);
`else
      check("nohalt_valid_pulses", vcount, 4);
      check("nohalt_pc",   bus.pc, 4);
      check("nohalt_flag", bus.halted, 0);
      cycles(10);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
